garbage_inserter: RTL and testbench

GARBAGE_INSERTER -- requirements
Module: garbage_inserter

---
 rtl/garbage_inserter_if.sv | 24 ++
 rtl/garbage_inserter.sv | 129 ++++++++++++
 tb/tb_garbage_inserter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/garbage_inserter_if.sv
// Request/response bundle between a board controller and the garbage-row inserter.
// `static` is a reserved word, so the sampled board travels as static_board.
interface garbage_inserter_if #(
    parameter int ROWS = 20,
    parameter int COLS = 10
);
    logic                 start;
    logic [2:0]           count;
    logic [0:ROWS*COLS-1] static_board;
    logic                 busy;
    logic                 done;
    logic                 topped_out;
    logic [0:ROWS*COLS-1] new_static;

    modport master (
        output start, count, static_board,
        input  busy, done, topped_out, new_static
    );

    modport slave (
        input  start, count, static_board,
        output busy, done, topped_out, new_static
    );
endinterface

// File: rtl/garbage_inserter.sv
// Pushes up to seven garbage rows (full rows with one LFSR-chosen hole) into the
// bottom of a static board, one row per cycle, flagging a top-out if row 0 is occupied.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the previous result
// LOAD  | board and count captured; decide whether any shifting is needed
// SHIFT | one garbage row per cycle until count exhausted or row 0 occupied
// DONE  | one-cycle completion pulse, new_static valid
module garbage_inserter #(
    parameter int         ROWS = 20,
    parameter int         COLS = 10,
    parameter logic [7:0] SEED = 8'h5A
) (
    input logic               clk,
    input logic               rst,
    garbage_inserter_if.slave bus
);
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [0:CELLS-1] work;
    logic [0:CELLS-1] work_next;
    logic [2:0]       remaining;
    logic [2:0]       remaining_next;
    logic             topped;
    logic             topped_next;
    logic [0:CELLS-1] result;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       lfsr;
    logic [3:0]       hole;
    logic [0:COLS-1]  garbage_row;
    logic             row0_occupied;

    // Free-running: successive rows always see successive LFSR values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign hole = (lfsr[3:0] < 4'd10) ? lfsr[3:0] : lfsr[3:0] - 4'd10;

    always_comb begin
        garbage_row = '1;
        for (int c = 0; c < COLS; c++) begin
            garbage_row[c] = (c != int'(hole));
        end
    end

    assign row0_occupied = |work[0:COLS-1];

    always_comb begin
        state_next     = state;
        work_next      = work;
        remaining_next = remaining;
        topped_next    = topped;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    work_next      = bus.static_board;
                    remaining_next = bus.count;
                    topped_next    = 1'b0;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                state_next = (remaining == 3'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (row0_occupied) begin
                    topped_next    = 1'b1;
                    remaining_next = '0;
                    state_next     = DONE;
                end else begin
                    work_next      = {work[COLS:CELLS-1], garbage_row};
                    remaining_next = remaining - 3'd1;
                    if (remaining == 3'd1) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            topped    <= 1'b0;
            result    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            work      <= work_next;
            remaining <= remaining_next;
            topped    <= topped_next;
            busy_q    <= (state_next != IDLE);
            done_q    <= (state_next == DONE);
            // Capture the post-shift board on the same edge that enters DONE.
            if (state_next == DONE) begin
                result <= work_next;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.topped_out = topped;
    assign bus.new_static = result;
endmodule

// File: tb/tb_garbage_inserter.sv
// Bench for garbage_inserter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a request-level model.
`timescale 1ns/1ps
module tb_garbage_inserter;
    localparam int         ROWS = 20;
    localparam int         COLS = 10;
    localparam int         N    = ROWS * COLS;
    localparam logic [7:0] SEED = 8'h5A;

    typedef logic [0:N-1] board_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    garbage_inserter_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    garbage_inserter #(.ROWS(ROWS), .COLS(COLS), .SEED(SEED)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input board_t act, input board_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int hole_of(input logic [7:0] l);
        int v;
        v = int'(l[3:0]);
        return (v < 10) ? v : v - 10;
    endfunction

    // l_accept is the LFSR value seen at the edge that accepts the request;
    // the k-th shift happens k+1 edges later.
    task automatic model_run(input board_t b, input int n, input logic [7:0] l_accept,
                             output board_t rb, output bit top, output int attempts);
        logic [7:0] l;
        bit occupied;
        int h;
        rb       = b;
        top      = 1'b0;
        attempts = 0;
        l        = lfsr_step(l_accept);
        for (int k = 1; k <= n; k++) begin
            l = lfsr_step(l);
            attempts++;
            occupied = 1'b0;
            for (int c = 0; c < COLS; c++) occupied |= rb[c];
            if (occupied) begin
                top = 1'b1;
                break;
            end
            h = hole_of(l);
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    rb[r*COLS + c] = rb[(r+1)*COLS + c];
            for (int c = 0; c < COLS; c++)
                rb[(ROWS-1)*COLS + c] = (c != h);
        end
    endtask

    logic [7:0] m_lfsr   = SEED;
    int         m_edge   = 0;
    bit         m_active = 1'b0;
    int         d_edge   = 0;
    board_t     r_board  = '0;
    bit         r_top    = 1'b0;
    logic       m_busy   = 1'b0;
    logic       m_done   = 1'b0;
    logic       m_topped = 1'b0;
    board_t     m_new    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr   = SEED;
            m_edge   = 0;
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_topped = 1'b0;
            m_new    = '0;
        end else begin : model_edge
            bit was_idle;
            int att;
            was_idle = !m_active;
            m_edge++;
            if (m_active && m_edge == d_edge + 1) begin
                m_active = 1'b0;
                m_busy   = 1'b0;
                m_done   = 1'b0;
            end else if (m_active && m_edge == d_edge) begin
                m_done   = 1'b1;
                m_topped = r_top;
                m_new    = r_board;
            end
            if (was_idle && bus.start === 1'b1) begin
                model_run(bus.static_board, int'(bus.count), m_lfsr, r_board, r_top, att);
                m_active = 1'b1;
                m_busy   = 1'b1;
                m_topped = 1'b0;
                d_edge   = m_edge + 1 + att;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        check_bit("busy", bus.busy, m_busy);
        check_bit("done", bus.done, m_done);
        check_bit("topped_out", bus.topped_out, m_topped);
        check_vec("new_static", bus.new_static, m_new);
        if (bus.done === 1'b1) done_seen++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic board_t rand_board();
        board_t b;
        int top;
        b   = '0;
        top = $urandom_range(0, ROWS);
        for (int r = top; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[r*COLS + c] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic issue(input board_t b, input logic [2:0] n);
        bus.start        = 1'b1;
        bus.count        = n;
        bus.static_board = b;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.count        = 3'($urandom_range(0, 7));
        bus.static_board = rand_board();
    endtask

    task automatic wait_done(input string name, output int waited);
        waited = 0;
        while (bus.done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_bit({name, "_done_seen"}, bus.done, 1'b1);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        board_t     b;
        int         waited;
        int         pulses;
        logic [9:0] row;

        bus.start        = 1'b0;
        bus.count        = '0;
        bus.static_board = '0;

        repeat (3) @(negedge clk);
        check_vec("reset_new_static", bus.new_static, '0);
        check_bit("reset_busy", bus.busy, 1'b0);

        // Empty board, one row, started on the first edge after reset.
        rst = 1'b0;
        issue('0, 3'd1);
        wait_done("one_row", waited);
        check_int("one_row_latency", waited, 2);
        row = bus.new_static[190:199];
        check_int("one_row_bottom", int'(row), int'(10'b1111111110));
        check_bit("one_row_upper_clear", |bus.new_static[0:189], 1'b0);
        check_bit("one_row_topped", bus.topped_out, 1'b0);
        gap(2);

        // Full bottom row pushed up by two garbage rows.
        b = '0;
        for (int c = 0; c < COLS; c++) b[190 + c] = 1'b1;
        issue(b, 3'd2);
        wait_done("two_rows", waited);
        check_int("two_rows_latency", waited, 3);
        row = bus.new_static[170:179];
        check_int("two_rows_row17", int'(row), int'(10'b1111111111));
        check_bit("two_rows_upper_clear", |bus.new_static[0:169], 1'b0);
        check_bit("two_rows_topped", bus.topped_out, 1'b0);
        gap(2);

        // Row 1 occupied: first shift lands it in row 0, second attempt tops out.
        b = '0;
        b[14] = 1'b1;
        issue(b, 3'd3);
        wait_done("topout", waited);
        check_int("topout_latency", waited, 3);
        check_bit("topout_flag", bus.topped_out, 1'b1);
        row = bus.new_static[0:9];
        check_int("topout_row0", int'(row), int'(10'b0000100000));
        check_bit("topout_mid_clear", |bus.new_static[10:189], 1'b0);
        gap(2);

        // count=0 passes the board straight through.
        b = rand_board();
        b[0] = 1'b1;
        issue(b, 3'd0);
        wait_done("zero_count", waited);
        check_int("zero_count_latency", waited, 1);
        check_vec("zero_count_board", bus.new_static, b);
        check_bit("zero_count_topped", bus.topped_out, 1'b0);
        gap(2);

        // start held high through the whole request yields one done pulse.
        pulses           = done_seen;
        bus.start        = 1'b1;
        bus.count        = 3'd2;
        bus.static_board = '0;
        gap(5);
        bus.start = 1'b0;
        gap(6);
        check_int("held_start_pulses", done_seen - pulses, 1);

        // Reset in the middle of SHIFT aborts the request.
        issue('0, 3'd5);
        gap(2);
        pulses = done_seen;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_bit("abort_busy", bus.busy, 1'b0);
        check_vec("abort_new_static", bus.new_static, '0);
        gap(2);
        check_int("abort_no_done", done_seen - pulses, 0);
        rst = 1'b0;
        issue('0, 3'd1);
        wait_done("after_abort", waited);
        check_int("after_abort_latency", waited, 2);
        row = bus.new_static[190:199];
        check_int("after_abort_bottom", int'(row), int'(10'b1111111110));
        gap(2);

        // Random traffic: starts at any time, inputs wiggle while busy, rare resets.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            bus.start        = ($urandom_range(0, 3) == 0);
            bus.count        = 3'($urandom_range(0, 7));
            bus.static_board = rand_board();
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        gap(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
